mem_pattern_tester: RTL and testbench

Synthesisable, parametrised memory tester that drives the cache front-end request port (addr / data_in / wr / rd / valid / done) of the memory system. It performs a write pass over a configurable word range with a selectable data pattern, then a read pass that regenerates the same pattern and checks every word. It records an error count, the first failing word and a per-transaction timeout, which makes it usable both on FPGA and as a self-checking bench driver.

---
 rtl/mem_defines.sv | 32 +++
 rtl/pattern_gen.sv | 55 +++++
 rtl/mem_pattern_tester.sv | 266 ++++++++++++++++++++++++++
 tb/tb_mem_pattern_tester.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_defines.sv
// Shared types and constants for the memory pattern tester.
package mem_defines;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WR_REQ = 3'd1,
    S_WR_GAP = 3'd2,
    S_RD_REQ = 3'd3,
    S_RD_GAP = 3'd4,
    S_FINISH = 3'd5
  } tester_state_t;

  typedef enum logic [1:0] {
    MODE_ADDR     = 2'd0,
    MODE_LFSR     = 2'd1,
    MODE_INV_ADDR = 2'd2,
    MODE_WALK1    = 2'd3
  } tester_mode_t;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // Right-shifting Galois step
  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0);
  endfunction

  // An all-zero LFSR would lock up, so a zero seed becomes 1
  function automatic logic [31:0] lfsr_seed(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

endpackage

// File: rtl/pattern_gen.sv
// Data pattern generator: LFSR state plus the per-mode data mux.
// o_data is the pattern of the word being issued this cycle; i_step advances the LFSR past it.
module pattern_gen
  import mem_defines::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned BIT_W  = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic              i_step,
  input  logic [31:0]       i_seed,
  input  tester_mode_t      i_mode,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [BIT_W-1:0]  i_bit,
  output logic [DATA_W-1:0] o_data
);

  logic [31:0]       r_lfsr;
  logic [31:0]       w_cur;
  logic [DATA_W-1:0] w_lfsr_data;

  // A load lets the seed itself serve as the word's value in the same cycle
  assign w_cur = i_load ? lfsr_seed(i_seed) : r_lfsr;

  generate
    if (DATA_W == 64) begin : g_wide
      assign w_lfsr_data = DATA_W'({~w_cur, w_cur});
    end else begin : g_narrow
      assign w_lfsr_data = DATA_W'(w_cur);
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lfsr <= 32'h1;
    end else if (i_step) begin
      r_lfsr <= lfsr_next(w_cur);
    end
  end

  always_comb begin
    o_data = '0;
    case (i_mode)
      MODE_ADDR:     o_data = DATA_W'(i_addr);
      MODE_LFSR:     o_data = w_lfsr_data;
      MODE_INV_ADDR: o_data = ~DATA_W'(i_addr);
      MODE_WALK1:    o_data = DATA_W'(1) << i_bit;
      default:       o_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_pattern_tester.sv
// Memory tester: writes a pattern over a word range, reads it back and checks it,
// reporting error count, first failing word and request timeouts.
module mem_pattern_tester
  import mem_defines::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned TIMEOUT  = 100,
  parameter int unsigned ERR_STOP = 0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [ADDR_W-1:0]   i_base_addr,
  input  logic [CNT_W-1:0]    i_num_words,
  input  logic [1:0]          i_mode,
  input  logic [31:0]         i_seed,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_pass,
  output logic                o_timeout,
  output logic [CNT_W-1:0]    o_err_cnt,
  output logic [ADDR_W-1:0]   o_fail_addr,
  output logic [DATA_W-1:0]   o_fail_exp,
  output logic [DATA_W-1:0]   o_fail_got,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic                o_mem_wr,
  output logic                o_mem_rd,
  output logic                o_mem_valid,
  output logic [DATA_W/8-1:0] o_mem_be,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  input  logic                i_mem_done
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned BIT_W = $clog2(DATA_W);
  localparam int unsigned TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  tester_state_t       r_state;
  tester_mode_t        r_mode;
  logic [31:0]         r_seed;
  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W-1:0]   r_addr;
  logic [CNT_W-1:0]    r_num;
  logic [CNT_W-1:0]    r_idx;
  logic [TO_W-1:0]     r_tcnt;
  logic                r_busy;
  logic                r_done;
  logic                r_pass;
  logic                r_timeout;
  logic [CNT_W-1:0]    r_err_cnt;
  logic [ADDR_W-1:0]   r_fail_addr;
  logic [DATA_W-1:0]   r_fail_exp;
  logic [DATA_W-1:0]   r_fail_got;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_wr;
  logic                r_rd;
  logic                r_valid;
  logic [DATA_W/8-1:0] r_be;

  logic                w_last;
  logic                w_load;
  logic                w_step;
  logic                w_tmo;
  logic                w_mismatch;
  tester_mode_t        w_mode;
  logic [31:0]         w_seed;
  logic [ADDR_W-1:0]   w_issue_addr;
  logic [CNT_W-1:0]    w_issue_idx;
  logic [DATA_W-1:0]   w_pattern;

  assign w_last     = (r_idx == r_num - CNT_W'(1));
  assign w_tmo      = (r_tcnt == TO_W'(TIMEOUT - 1));
  // During reads the expected word is carried on the write-data register
  assign w_mismatch = (i_mem_rdata != r_wdata);

  // Address, index and LFSR control for the word issued at the coming edge
  always_comb begin
    w_mode       = r_mode;
    w_seed       = r_seed;
    w_load       = 1'b0;
    w_step       = 1'b0;
    w_issue_addr = r_addr + ADDR_W'(BYTES);
    w_issue_idx  = r_idx + CNT_W'(1);
    case (r_state)
      S_IDLE: begin
        w_mode       = tester_mode_t'(i_mode);
        w_seed       = i_seed;
        w_issue_addr = i_base_addr;
        w_issue_idx  = '0;
        w_load       = 1'b1;
        w_step       = i_start && (i_num_words != '0);
      end
      S_WR_GAP: begin
        w_step = 1'b1;
        if (w_last) begin
          w_issue_addr = r_base;
          w_issue_idx  = '0;
          w_load       = 1'b1;
        end
      end
      S_RD_GAP: w_step = !w_last;
      default: ;
    endcase
  end

  pattern_gen #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .BIT_W  (BIT_W)
  ) u_pattern_gen (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_load),
    .i_step (w_step),
    .i_seed (w_seed),
    .i_mode (w_mode),
    .i_addr (w_issue_addr),
    .i_bit  (w_issue_idx[BIT_W-1:0]),
    .o_data (w_pattern)
  );

  // Control FSM with all outputs registered
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_mode      <= MODE_ADDR;
      r_seed      <= '0;
      r_base      <= '0;
      r_addr      <= '0;
      r_num       <= '0;
      r_idx       <= '0;
      r_tcnt      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
      r_err_cnt   <= '0;
      r_fail_addr <= '0;
      r_fail_exp  <= '0;
      r_fail_got  <= '0;
      r_wdata     <= '0;
      r_wr        <= 1'b0;
      r_rd        <= 1'b0;
      r_valid     <= 1'b0;
      r_be        <= '0;
    end else begin
      r_be   <= '1;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_base      <= i_base_addr;
            r_num       <= i_num_words;
            r_mode      <= tester_mode_t'(i_mode);
            r_seed      <= i_seed;
            r_addr      <= i_base_addr;
            r_idx       <= '0;
            r_tcnt      <= '0;
            r_wdata     <= w_pattern;
            r_err_cnt   <= '0;
            r_timeout   <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_addr <= '0;
            r_fail_exp  <= '0;
            r_fail_got  <= '0;
            if (i_num_words == '0) begin
              r_state <= S_FINISH;
              r_done  <= 1'b1;
              r_pass  <= 1'b1;
            end else begin
              r_state <= S_WR_REQ;
              r_busy  <= 1'b1;
              r_valid <= 1'b1;
              r_wr    <= 1'b1;
            end
          end
        end
        S_WR_REQ, S_RD_REQ: begin
          // Completion wins over a timeout landing in the same cycle
          if (i_mem_done) begin
            r_valid <= 1'b0;
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_state <= (r_state == S_WR_REQ) ? S_WR_GAP : S_RD_GAP;
            if ((r_state == S_RD_REQ) && w_mismatch) begin
              if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_W'(1);
              if (r_err_cnt == '0) begin
                r_fail_addr <= r_addr;
                r_fail_exp  <= r_wdata;
                r_fail_got  <= i_mem_rdata;
              end
              if (ERR_STOP != 0) begin
                r_state <= S_FINISH;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_pass  <= 1'b0;
              end
            end
          end else if (w_tmo) begin
            r_valid   <= 1'b0;
            r_wr      <= 1'b0;
            r_rd      <= 1'b0;
            r_timeout <= 1'b1;
            r_state   <= S_FINISH;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_pass    <= 1'b0;
          end else begin
            r_tcnt <= r_tcnt + TO_W'(1);
          end
        end
        S_WR_GAP: begin
          r_tcnt  <= '0;
          r_valid <= 1'b1;
          r_wdata <= w_pattern;
          r_addr  <= w_issue_addr;
          r_idx   <= w_issue_idx;
          if (w_last) begin
            r_state <= S_RD_REQ;
            r_rd    <= 1'b1;
          end else begin
            r_state <= S_WR_REQ;
            r_wr    <= 1'b1;
          end
        end
        S_RD_GAP: begin
          if (w_last) begin
            r_state <= S_FINISH;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_pass  <= (r_err_cnt == '0);
          end else begin
            r_tcnt  <= '0;
            r_valid <= 1'b1;
            r_rd    <= 1'b1;
            r_wdata <= w_pattern;
            r_addr  <= w_issue_addr;
            r_idx   <= w_issue_idx;
            r_state <= S_RD_REQ;
          end
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_timeout   = r_timeout;
  assign o_err_cnt   = r_err_cnt;
  assign o_fail_addr = r_fail_addr;
  assign o_fail_exp  = r_fail_exp;
  assign o_fail_got  = r_fail_got;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
  assign o_mem_wr    = r_wr;
  assign o_mem_rd    = r_rd;
  assign o_mem_valid = r_valid;
  assign o_mem_be    = r_be;

endmodule

// File: tb/tb_mem_pattern_tester.sv
// Bench for mem_pattern_tester: responding memory model plus a word-level reference model.
module tb_mem_pattern_tester;

  localparam int unsigned TIMEOUT = 100;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] num_words = '0;
  logic [1:0]  mode = '0;
  logic [31:0] seed = '0;
  logic        busy, done, pass, timeout;
  logic [15:0] err_cnt;
  logic [31:0] fail_addr, fail_exp, fail_got;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_wr, mem_rd, mem_valid, mem_done;
  logic [3:0]  mem_be;

  int errors = 0;
  int checks = 0;

  int          lat_min = 1;
  int          lat_max = 1;
  bit          silent = 1'b0;
  bit          corrupt_en = 1'b0;
  logic [31:0] corrupt_addr = '0;
  logic [31:0] corrupt_mask = '0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          rd_count = 0;
  int          valid_cycles = 0;
  int          be_bad = 0;
  logic [31:0] mem [logic [31:0]];

  mem_pattern_tester #(
    .ADDR_W(32), .DATA_W(32), .CNT_W(16), .TIMEOUT(TIMEOUT), .ERR_STOP(0)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_base_addr(base_addr),
    .i_num_words(num_words), .i_mode(mode), .i_seed(seed),
    .o_busy(busy), .o_done(done), .o_pass(pass), .o_timeout(timeout),
    .o_err_cnt(err_cnt), .o_fail_addr(fail_addr), .o_fail_exp(fail_exp),
    .o_fail_got(fail_got), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .o_mem_wr(mem_wr), .o_mem_rd(mem_rd), .o_mem_valid(mem_valid),
    .o_mem_be(mem_be), .i_mem_rdata(mem_rdata), .i_mem_done(mem_done)
  );

  always #5 clk = ~clk;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Memory: answers each request after a random latency, optionally corrupting one word on read
  initial begin : responder
    int wait_cnt;
    int lat;
    wait_cnt  = 0;
    lat       = 1;
    mem_done  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_done = 1'b0;
      if (mem_valid !== 1'b1) begin
        wait_cnt = 0;
      end else begin
        if (wait_cnt == 0) lat = $urandom_range(lat_max, lat_min);
        valid_cycles++;
        if (mem_be !== 4'hF) be_bad++;
        wait_cnt++;
        if (!silent && wait_cnt >= lat) begin
          mem_done = 1'b1;
          wait_cnt = 0;
          if (mem_wr === 1'b1) begin
            mem[mem_addr] = mem_wdata;
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
          end
          if (mem_rd === 1'b1) begin
            rd_count++;
            mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
            if (corrupt_en && mem_addr == corrupt_addr) mem_rdata = mem_rdata ^ corrupt_mask;
          end
        end
      end
    end
  end

  function automatic logic [31:0] mdl_addr(input logic [31:0] b, input int i);
    return b + 32'(i) * 32'd4;
  endfunction

  function automatic logic [31:0] mdl_data(input logic [1:0] m, input logic [31:0] b,
                                           input logic [31:0] s, input int i);
    logic [31:0] a;
    logic [31:0] l;
    logic [31:0] r;
    a = mdl_addr(b, i);
    l = (s == 32'h0) ? 32'h1 : s;
    for (int k = 0; k < i; k++) l = l[0] ? ((l >> 1) ^ TAPS) : (l >> 1);
    case (m)
      2'd0:    r = a;
      2'd1:    r = l;
      2'd2:    r = ~a;
      default: r = 32'h1 << (i % 32);
    endcase
    return r;
  endfunction

  function automatic int count_wr_diffs(input logic [1:0] m, input logic [31:0] b,
                                        input logic [31:0] s, input int n);
    int d;
    d = (wr_addr_q.size() != n) ? 1 : 0;
    for (int i = 0; i < n && i < wr_addr_q.size(); i++)
      if (wr_addr_q[i] !== mdl_addr(b, i) || wr_data_q[i] !== mdl_data(m, b, s, i)) d++;
    return d;
  endfunction

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_count     = 0;
    valid_cycles = 0;
    be_bad       = 0;
  endtask

  // Launch a test and wait for done; optionally pulse start again at cycle 'poke' while busy
  task automatic run_test(input logic [1:0] m, input logic [31:0] b, input logic [15:0] n,
                          input logic [31:0] s, input int poke, output int cyc);
    clear_log();
    @(negedge clk);
    mode = m; base_addr = b; num_words = n; seed = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 3000) begin
      if (cyc == poke) begin
        start = 1'b1; base_addr = b ^ 32'h0000_4000; num_words = n + 16'd3; mode = ~m;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL run_done: no done after %0d cycles (required done=1)", cyc);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, pass, timeout, mem_valid, mem_wr, mem_rd} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 0000000", {busy, done, pass, timeout, mem_valid, mem_wr, mem_rd});
    end
    checks++;
    if ({err_cnt, fail_addr, fail_exp, fail_got, mem_addr, mem_wdata, mem_be} !== '0) begin
      errors++;
      $display("FAIL reset_values: err=%h faddr=%h addr=%h wdata=%h be=%h required all zero",
               err_cnt, fail_addr, mem_addr, mem_wdata, mem_be);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_addr_pattern();
    int cyc;
    int d;
    lat_min = 2; lat_max = 2; corrupt_en = 1'b0; silent = 1'b0;
    run_test(2'd0, 32'h0, 16'd4, 32'h0, -1, cyc);
    d = count_wr_diffs(2'd0, 32'h0, 32'h0, 4);
    checks++;
    if (d !== 0) begin errors++; $display("FAIL addr_writes: %0d bad writes, required 0", d); end
    checks++;
    if (cyc !== 25) begin errors++; $display("FAIL addr_latency: done at cycle %0d, required 25", cyc); end
    checks++;
    if (rd_count !== 4) begin errors++; $display("FAIL addr_reads: got %0d required 4", rd_count); end
    checks++;
    if ({pass, busy, timeout, err_cnt} !== {1'b1, 1'b0, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL addr_status: pass=%b busy=%b tmo=%b err=%0d required 1 0 0 0", pass, busy, timeout, err_cnt);
    end
    checks++;
    if (be_bad !== 0) begin errors++; $display("FAIL byte_enables: %0d cycles not all ones", be_bad); end
    @(negedge clk);
    checks++;
    if ({done, pass} !== 2'b01) begin
      errors++;
      $display("FAIL done_pulse: done=%b pass=%b after pulse, required 0 1", done, pass);
    end
  endtask

  task automatic test_lfsr();
    int cyc;
    logic [31:0] exp_d [3];
    exp_d[0] = 32'h0000_0001; exp_d[1] = 32'h8020_0003; exp_d[2] = 32'hC030_0002;
    lat_min = 1; lat_max = 1;
    run_test(2'd1, 32'h0000_0200, 16'd3, 32'h0, -1, cyc);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (wr_data_q.size() <= i || wr_data_q[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL lfsr_word%0d: got %h required %h", i,
                 (wr_data_q.size() > i) ? wr_data_q[i] : 32'hx, exp_d[i]);
      end
    end
    checks++;
    if ({pass, cyc} !== {1'b1, 32'd13}) begin
      errors++;
      $display("FAIL lfsr_status: pass=%b cycle=%0d required 1 13", pass, cyc);
    end
  endtask

  task automatic test_corrupt();
    int cyc;
    lat_min = 1; lat_max = 3;
    corrupt_en = 1'b1; corrupt_addr = 32'h108; corrupt_mask = 32'h1;
    run_test(2'd0, 32'h100, 16'd4, 32'h0, -1, cyc);
    corrupt_en = 1'b0;
    checks++;
    if ({err_cnt, fail_addr, fail_exp, fail_got} !== {16'd1, 32'h108, 32'h108, 32'h109}) begin
      errors++;
      $display("FAIL corrupt_capture: err=%0d addr=%h exp=%h got=%h required 1 108 108 109",
               err_cnt, fail_addr, fail_exp, fail_got);
    end
    checks++;
    if ({pass, timeout} !== 2'b00) begin
      errors++;
      $display("FAIL corrupt_pass: pass=%b timeout=%b required 0 0", pass, timeout);
    end
  endtask

  task automatic test_timeout();
    int cyc;
    silent = 1'b1;
    run_test(2'd0, 32'h2000, 16'd3, 32'h0, -1, cyc);
    silent = 1'b0;
    checks++;
    if ({timeout, mem_valid, pass, busy} !== 4'b1000) begin
      errors++;
      $display("FAIL tmo_status: tmo=%b valid=%b pass=%b busy=%b required 1 0 0 0", timeout, mem_valid, pass, busy);
    end
    checks++;
    if (valid_cycles !== TIMEOUT || cyc !== TIMEOUT + 1) begin
      errors++;
      $display("FAIL tmo_length: valid %0d cycles, done at %0d, required %0d and %0d",
               valid_cycles, cyc, TIMEOUT, TIMEOUT + 1);
    end
    // A reply arriving in the very last allowed cycle still counts as completion
    lat_min = TIMEOUT; lat_max = TIMEOUT;
    run_test(2'd2, 32'h2000, 16'd1, 32'h0, -1, cyc);
    checks++;
    if ({timeout, pass, cyc} !== {1'b0, 1'b1, 32'(2 * (TIMEOUT + 1) + 1)}) begin
      errors++;
      $display("FAIL tmo_boundary: tmo=%b pass=%b cycle=%0d required 0 1 %0d",
               timeout, pass, cyc, 2 * (TIMEOUT + 1) + 1);
    end
  endtask

  task automatic test_zero_words();
    int cyc;
    int d;
    lat_min = 1; lat_max = 1;
    run_test(2'd0, 32'h40, 16'd0, 32'h0, -1, cyc);
    checks++;
    if ({cyc, pass, err_cnt} !== {32'd1, 1'b1, 16'd0}) begin
      errors++;
      $display("FAIL zero_words: done at %0d pass=%b err=%0d required 1 1 0", cyc, pass, err_cnt);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (valid_cycles !== 0) begin
      errors++;
      $display("FAIL zero_no_request: %0d valid cycles, required 0", valid_cycles);
    end
    run_test(2'd3, 32'h40, 16'd6, 32'h55, 4, cyc);
    d = count_wr_diffs(2'd3, 32'h40, 32'h55, 6);
    checks++;
    if ({d, cyc, pass} !== {32'd0, 32'd25, 1'b1}) begin
      errors++;
      $display("FAIL start_while_busy: bad=%0d cycle=%0d pass=%b required 0 25 1", d, cyc, pass);
    end
  endtask

  task automatic test_random();
    int cyc;
    int d;
    int k;
    logic [1:0]  m;
    logic [31:0] b, s, ex;
    logic [15:0] n;
    for (int it = 0; it < 8; it++) begin
      m = 2'($urandom_range(3, 0));
      b = (it == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      n = 16'($urandom_range(16, 1));
      s = (it == 1) ? 32'h0 : $urandom;
      lat_min = 1; lat_max = 4;
      corrupt_en = ($urandom_range(1, 0) == 1);
      k = $urandom_range(int'(n) - 1, 0);
      corrupt_addr = mdl_addr(b, k);
      corrupt_mask = $urandom | 32'h0000_0100;
      run_test(m, b, n, s, -1, cyc);
      d = count_wr_diffs(m, b, s, int'(n));
      checks++;
      if (d !== 0) begin errors++; $display("FAIL rand%0d_writes: %0d bad writes mode=%0d", it, d, m); end
      if (corrupt_en) begin
        ex = mdl_data(m, b, s, k);
        checks++;
        if ({err_cnt, pass, fail_addr, fail_exp, fail_got} !==
            {16'd1, 1'b0, corrupt_addr, ex, ex ^ corrupt_mask}) begin
          errors++;
          $display("FAIL rand%0d_err: err=%0d pass=%b addr=%h exp=%h got=%h required 1 0 %h %h %h",
                   it, err_cnt, pass, fail_addr, fail_exp, fail_got, corrupt_addr, ex, ex ^ corrupt_mask);
        end
      end else begin
        checks++;
        if ({err_cnt, pass} !== {16'd0, 1'b1}) begin
          errors++;
          $display("FAIL rand%0d_clean: err=%0d pass=%b required 0 1", it, err_cnt, pass);
        end
      end
    end
    corrupt_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int cyc;
    int d;
    clear_log();
    lat_min = 1; lat_max = 1;
    corrupt_en = 1'b1; corrupt_addr = 32'h3000; corrupt_mask = 32'h8;
    @(negedge clk);
    mode = 2'd2; base_addr = 32'h3000; num_words = 16'd5; seed = 32'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (rd_count < 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if ({rd_count >= 2, err_cnt} !== {1'b1, 16'd1}) begin
      errors++;
      $display("FAIL midrun_pre: reads=%0d err=%0d required >=2 and 1", rd_count, err_cnt);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_valid, busy, err_cnt} !== {1'b0, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL midrun_reset: valid=%b busy=%b err=%0d required 0 0 0", mem_valid, busy, err_cnt);
    end
    rst = 1'b0;
    corrupt_en = 1'b0;
    run_test(2'd2, 32'h3000, 16'd5, 32'h0, -1, cyc);
    d = count_wr_diffs(2'd2, 32'h3000, 32'h0, 5);
    checks++;
    if ({d, pass, err_cnt} !== {32'd0, 1'b1, 16'd0}) begin
      errors++;
      $display("FAIL midrun_restart: bad=%0d pass=%b err=%0d required 0 1 0", d, pass, err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_addr_pattern();
    test_lfsr();
    test_corrupt();
    test_timeout();
    test_zero_words();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
